last_deq_vt_cache: RTL
======================

# last_deq_vt_cache

Per-tile cache, indexed by locale, holding the timestamp of the most recently dequeued task for each locale. It sits beside the commit-queue dequeue path. When a task is being dequeued, the CQ looks up the task's locale here. If the task's timestamp is strictly larger than the cached one, the CQ skips the full locale-conflict check. The CQ writes an entry on every dequeue and can flush the whole cache, for example after an abort storm.

## Interface
Parameters:
- LOG_ENTRIES, 9, log2 of entry count; must be >=4, or 0 to disable the cache (every lookup misses, no storage).
- LOCALE_WIDTH, 32, locale width.
- TS_WIDTH, 32, timestamp width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ready  out  1  1 = cache usable; 0 while a flush sweep is running.
- lookup_valid  in  1  lookup request.
- lookup_locale  in  LOCALE_WIDTH  locale to look up.
- lookup_ts  in  TS_WIDTH  timestamp of the dequeuing task.
- resp_valid  out  1  lookup response, exactly 1 cycle after lookup_valid.
- resp_hit  out  1  tag match on a valid entry.
- resp_bypass  out  1  resp_hit && lookup_ts > cached ts; the conflict check may be skipped.
- update_valid  in  1  a dequeue occurred.
- update_locale  in  LOCALE_WIDTH  locale of the dequeued task.
- update_ts  in  TS_WIDTH  timestamp of the dequeued task.
- flush  in  1  one-cycle pulse that invalidates all entries.

## Operation
Entry format and addressing:
- Direct-mapped. Index = locale[LOG_ENTRIES-1:0]; tag = locale[LOCALE_WIDTH-1:LOG_ENTRIES].
- Entry = {valid, tag, ts}, held in 1-read/1-write block RAM.
- Valid bits are not reset by a RAM reset; they are cleared by the sweep below.

State machine (two states, SWEEP and RUN):
- SWEEP: a counter walks indices 0..2^LOG_ENTRIES-1, writing valid=0 at one index per cycle. ready=0. After writing the last index, the next state is RUN.
- RUN: ready=1. Lookups and updates are serviced.
- reset puts the block in SWEEP with the counter at 0.
- flush in any state puts the block in SWEEP with the counter at 0. A flush during a sweep restarts the sweep.

Lookup:
- The RAM read is issued in the cycle lookup_valid is high.
- The response is computed in the next cycle from the read data and the registered lookup_ts and tag.
- TS comparison is unsigned over TS_WIDTH. Equal timestamps give resp_bypass=0.

Update:
- In RUN, update_valid writes {1, tag, update_ts} unconditionally. This replaces any entry at that index, including one with a different tag or a larger ts.
- In SWEEP, updates are dropped. This is safe because an empty cache is conservative.

Same-index collisions:
- Lookup and update in the same cycle to the same index: the response reflects the update (write-first forwarding). Hit and bypass are computed against update_ts and the update's tag.
- Update in cycle t, lookup in cycle t+1: the lookup reads the written value.
- Lookups in SWEEP, and a lookup in the cycle flush is asserted: resp_valid is still produced 1 cycle later, with resp_hit=0 and resp_bypass=0.

Disabled cache (LOG_ENTRIES=0):
- No RAM.
- ready=1 one cycle after reset deasserts.
- resp_valid still tracks lookup_valid with 1 cycle latency; resp_hit and resp_bypass are constant 0.

## Timing
- Reset values: ready=0, resp_valid=0, resp_hit=0, resp_bypass=0, state=SWEEP, counter=0.
- Lookup latency: 1 cycle. Lookups are fully pipelined, one per cycle, with no back-pressure.
- Update: takes effect at the end of its cycle.
- Sweep: 2^LOG_ENTRIES cycles. ready rises in the cycle after the last index is written, so 512 cycles after reset deasserts for LOG_ENTRIES=9.
- reset asserted mid-operation: any in-flight lookup's resp_valid is 0 in the following cycle, and the sweep restarts.
- lookup_valid and update_valid have no ready handshake. The CQ must not treat resp_bypass as meaningful unless ready was 1 in the lookup cycle; resp_bypass is 0 in that case regardless.

## Test plan
- Reset sweep: deassert reset. Expect ready=0 for exactly 512 cycles, then ready=1. A lookup issued at cycle 100 must return resp_valid=1, hit=0, bypass=0.
- Basic hit/bypass: update(locale=0x1234, ts=50). Then:
  - lookup(0x1234, ts=51) -> hit=1, bypass=1.
  - lookup(0x1234, ts=50) -> hit=1, bypass=0.
  - lookup(0x1234, ts=49) -> hit=1, bypass=0.
- Tag conflict: update(0x0034, ts=10) then update(0x1034, ts=90), which maps to the same index.
  - lookup(0x0034, ts=20) -> hit=0, bypass=0.
  - lookup(0x1034, ts=95) -> hit=1, bypass=1.
- Same-cycle forwarding: existing entry (0x77, ts=100). Issue update(0x77, ts=5) together with lookup(0x77, ts=6) -> next cycle hit=1, bypass=1.
- Flush: fill 20 locales, then pulse flush.
  - Expect ready=0 for 512 cycles.
  - An update during the flush is dropped: looking up its locale after ready=1 gives hit=0.
  - All 20 prior locales give hit=0.
  - A second flush pulse at sweep cycle 300 extends ready=0 to 812 cycles total.
- Disabled build (LOG_ENTRIES=0): random lookups and updates give resp_valid = lookup_valid delayed 1 cycle, with hit=0 and bypass=0 always; ready=1 from cycle 1.

Source files
------------

// File: rtl/last_deq_vt_cache_if.sv
// Bus between the commit queue (master) and the last-dequeue timestamp cache (slave).
//
// Handshake semantics: lookup_valid and update_valid are single-cycle requests with no
// back-pressure; the cache takes one of each every cycle. resp_valid follows lookup_valid
// exactly one cycle later. ready is advisory only: when ready was 0 in the lookup cycle
// the response still arrives, but resp_hit and resp_bypass are forced to 0.
interface last_deq_vt_cache_if #(
  parameter int LOCALE_WIDTH = 32,
  parameter int TS_WIDTH     = 32
);
  logic                    ready;
  logic                    lookup_valid;
  logic [LOCALE_WIDTH-1:0] lookup_locale;
  logic [TS_WIDTH-1:0]     lookup_ts;
  logic                    resp_valid;
  logic                    resp_hit;
  logic                    resp_bypass;
  logic                    update_valid;
  logic [LOCALE_WIDTH-1:0] update_locale;
  logic [TS_WIDTH-1:0]     update_ts;
  logic                    flush;
  // Debug view of the controller state: 0 = SWEEP, 1 = RUN.
  logic                    dbg_state;

  modport master (
    input  ready, resp_valid, resp_hit, resp_bypass, dbg_state,
    output lookup_valid, lookup_locale, lookup_ts,
    output update_valid, update_locale, update_ts, flush
  );

  modport slave (
    output ready, resp_valid, resp_hit, resp_bypass, dbg_state,
    input  lookup_valid, lookup_locale, lookup_ts,
    input  update_valid, update_locale, update_ts, flush
  );
endinterface

// File: rtl/last_deq_vt_cache.sv
// Direct-mapped per-locale cache of the most recently dequeued task timestamp.
// A lookup whose timestamp is strictly newer than the cached one lets the commit
// queue skip its locale-conflict check. A sweep clears all valid bits after reset
// or flush; LOG_ENTRIES = 0 builds a storage-free variant that always misses.
module last_deq_vt_cache #(
  parameter int LOG_ENTRIES  = 9,
  parameter int LOCALE_WIDTH = 32,
  parameter int TS_WIDTH     = 32
) (
  input logic               clk,
  input logic               reset,
  last_deq_vt_cache_if.slave bus
);

  if (LOG_ENTRIES == 0) begin : g_off

    logic ready_q;
    logic resp_valid_q;

    // Response strobe tracks lookups with one cycle of latency; ready rises after reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        ready_q      <= 1'b0;
        resp_valid_q <= 1'b0;
      end else begin
        ready_q      <= 1'b1;
        resp_valid_q <= bus.lookup_valid;
      end
    end

    assign bus.ready       = ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_hit    = 1'b0;
    assign bus.resp_bypass = 1'b0;
    assign bus.dbg_state   = ready_q;

  end else begin : g_on

    localparam int ENTRIES = 1 << LOG_ENTRIES;
    localparam int TAG_W   = LOCALE_WIDTH - LOG_ENTRIES;
    localparam int ENTRY_W = 1 + TAG_W + TS_WIDTH;

    typedef enum logic {
      ST_SWEEP = 1'b0,
      ST_RUN   = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [LOG_ENTRIES-1:0] cnt_q, cnt_d;

    // Entry layout: {valid, tag, ts}.
    logic [ENTRY_W-1:0]     mem [ENTRIES];
    logic [ENTRY_W-1:0]     rd_q;

    logic                   wr_en;
    logic [LOG_ENTRIES-1:0] wr_idx;
    logic [ENTRY_W-1:0]     wr_data;

    logic [LOG_ENTRIES-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0]       lk_tag, upd_tag;
    logic                   usable;
    logic                   upd_en;

    // Registered lookup context used to form the response one cycle later.
    logic                   lk_valid_q;
    logic                   lk_usable_q;
    logic                   fwd_q;
    logic [TAG_W-1:0]       lk_tag_q;
    logic [TS_WIDTH-1:0]    lk_ts_q;
    logic [TAG_W-1:0]       fwd_tag_q;
    logic [TS_WIDTH-1:0]    fwd_ts_q;

    logic                   ent_valid;
    logic [TAG_W-1:0]       ent_tag;
    logic [TS_WIDTH-1:0]    ent_ts;
    logic                   hit;

    assign lk_idx  = bus.lookup_locale[LOG_ENTRIES-1:0];
    assign lk_tag  = bus.lookup_locale[LOCALE_WIDTH-1:LOG_ENTRIES];
    assign upd_idx = bus.update_locale[LOG_ENTRIES-1:0];
    assign upd_tag = bus.update_locale[LOCALE_WIDTH-1:LOG_ENTRIES];

    // A flush cycle is treated as already sweeping: no hits, no updates.
    assign usable = (state_q == ST_RUN) && !bus.flush;
    assign upd_en = usable && bus.update_valid;

    // Controller state and sweep counter register.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_SWEEP;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next state and RAM write port: sweep clears one index per cycle, run takes updates.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_idx  = upd_idx;
      wr_data = {1'b1, upd_tag, bus.update_ts};
      case (state_q)
        ST_SWEEP: begin
          wr_en   = 1'b1;
          wr_idx  = cnt_q;
          wr_data = '0;
          cnt_d   = cnt_q + 1'b1;
          if (&cnt_q) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          wr_en = upd_en;
        end
        default: begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      endcase
      if (bus.flush) begin
        state_d = ST_SWEEP;
        cnt_d   = '0;
      end
    end

    // Single-port-per-direction block RAM; read data is the pre-write contents.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_idx] <= wr_data;
      end
      if (bus.lookup_valid) begin
        rd_q <= mem[lk_idx];
      end
    end

    // Lookup pipeline control, cleared by reset so in-flight lookups are dropped.
    always_ff @(posedge clk) begin
      if (reset) begin
        lk_valid_q  <= 1'b0;
        lk_usable_q <= 1'b0;
        fwd_q       <= 1'b0;
      end else begin
        lk_valid_q  <= bus.lookup_valid;
        lk_usable_q <= bus.lookup_valid && usable;
        fwd_q       <= upd_en && (upd_idx == lk_idx);
      end
    end

    // Lookup pipeline data, including the same-cycle update to forward over the RAM read.
    always_ff @(posedge clk) begin
      if (bus.lookup_valid) begin
        lk_tag_q  <= lk_tag;
        lk_ts_q   <= bus.lookup_ts;
        fwd_tag_q <= upd_tag;
        fwd_ts_q  <= bus.update_ts;
      end
    end

    // Write-first view of the entry, then tag match and strict timestamp compare.
    always_comb begin
      ent_valid = rd_q[ENTRY_W-1];
      ent_tag   = rd_q[TS_WIDTH +: TAG_W];
      ent_ts    = rd_q[TS_WIDTH-1:0];
      if (fwd_q) begin
        ent_valid = 1'b1;
        ent_tag   = fwd_tag_q;
        ent_ts    = fwd_ts_q;
      end
    end

    assign hit             = lk_usable_q && ent_valid && (ent_tag == lk_tag_q);
    assign bus.ready       = (state_q == ST_RUN);
    assign bus.resp_valid  = lk_valid_q;
    assign bus.resp_hit    = hit;
    assign bus.resp_bypass = hit && (lk_ts_q > ent_ts);
    assign bus.dbg_state   = state_q;

  end

endmodule
